// File: rtl/demux1to2_stream.sv
// Registered 1-to-2 stream demultiplexer with select or broadcast steering.
// Each output owns a one-entry holding slot and a delivered-beat counter.
module demux1to2_stream #(
  parameter int unsigned DWidth   = 32,
  parameter int unsigned CntWidth = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                valid_i,
  output logic                ready_o,
  input  logic [DWidth-1:0]   data_i,
  input  logic                select_i,
  input  logic                broadcast_i,
  output logic                valid0_o,
  input  logic                ready0_i,
  output logic [DWidth-1:0]   data0_o,
  output logic [CntWidth-1:0] count0_o,
  output logic                valid1_o,
  input  logic                ready1_i,
  output logic [DWidth-1:0]   data1_o,
  output logic [CntWidth-1:0] count1_o
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_e;

  slot_e                slot0_q, slot0_d;
  slot_e                slot1_q, slot1_d;
  logic [DWidth-1:0]    data0_q, data0_d;
  logic [DWidth-1:0]    data1_q, data1_d;
  logic [CntWidth-1:0]  count0_q, count0_d;
  logic [CntWidth-1:0]  count1_q, count1_d;

  logic can0, can1, accept, load0, load1, drain0, drain1;

  always_comb begin
    // Reset presents both slots as EMPTY to the upstream, but blocks the accept.
    can0   = rst_i || (slot0_q == EMPTY) || ready0_i;
    can1   = rst_i || (slot1_q == EMPTY) || ready1_i;
    if (broadcast_i) begin
      ready_o = can0 && can1;
    end else if (select_i) begin
      ready_o = can1;
    end else begin
      ready_o = can0;
    end
    accept = valid_i && ready_o && !rst_i;
    load0  = accept && (broadcast_i || !select_i);
    load1  = accept && (broadcast_i ||  select_i);
    drain0 = (slot0_q == FULL) && ready0_i;
    drain1 = (slot1_q == FULL) && ready1_i;
  end

  always_comb begin
    slot0_d  = slot0_q;
    slot1_d  = slot1_q;
    data0_d  = data0_q;
    data1_d  = data1_q;
    count0_d = count0_q;
    count1_d = count1_q;

    // A reload wins over a drain so a full-rate stream keeps the slot FULL.
    if (load0) begin
      slot0_d = FULL;
      data0_d = data_i;
    end else if (drain0) begin
      slot0_d = EMPTY;
    end
    if (load1) begin
      slot1_d = FULL;
      data1_d = data_i;
    end else if (drain1) begin
      slot1_d = EMPTY;
    end

    if (drain0) count0_d = count0_q + 1'b1;
    if (drain1) count1_d = count1_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      slot0_q  <= EMPTY;
      slot1_q  <= EMPTY;
      data0_q  <= '0;
      data1_q  <= '0;
      count0_q <= '0;
      count1_q <= '0;
    end else begin
      slot0_q  <= slot0_d;
      slot1_q  <= slot1_d;
      data0_q  <= data0_d;
      data1_q  <= data1_d;
      count0_q <= count0_d;
      count1_q <= count1_d;
    end
  end

  assign valid0_o = (slot0_q == FULL);
  assign valid1_o = (slot1_q == FULL);
  assign data0_o  = data0_q;
  assign data1_o  = data1_q;
  assign count0_o = count0_q;
  assign count1_o = count1_q;

endmodule

// File: tb/tb_demux1to2_stream.sv
// Directed bench for demux1to2_stream: steering, backpressure, broadcast,
// 4-bit counter wrap and mid-transfer reset, with hand-derived expectations.
module tb_demux1to2_stream;

  localparam int unsigned DW = 32;
  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          valid_i, ready_o, select_i, broadcast_i;
  logic [DW-1:0] data_i;
  logic          valid0, ready0, valid1, ready1;
  logic [DW-1:0] data0, data1;
  logic [CW-1:0] count0, count1;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  demux1to2_stream #(.DWidth(DW), .CntWidth(CW)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .valid_i    (valid_i),
    .ready_o    (ready_o),
    .data_i     (data_i),
    .select_i   (select_i),
    .broadcast_i(broadcast_i),
    .valid0_o   (valid0),
    .ready0_i   (ready0),
    .data0_o    (data0),
    .count0_o   (count0),
    .valid1_o   (valid1),
    .ready1_i   (ready1),
    .data1_o    (data1),
    .count1_o   (count1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic v, input logic sel, input logic bc, input logic [DW-1:0] d);
    valid_i     = v;
    select_i    = sel;
    broadcast_i = bc;
    data_i      = d;
    #1;
  endtask

  initial begin
    rst = 1'b1; ready0 = 1'b0; ready1 = 1'b0;
    beat(1'b0, 1'b0, 1'b0, '0);
    tick();
    chk("rst_ready", 32'(ready_o), 32'd1);
    tick();
    rst = 1'b0;
    #1;
    chk("rst_valid0", 32'(valid0), 32'd0);
    chk("rst_valid1", 32'(valid1), 32'd0);
    chk("rst_data0", data0, 32'd0);
    chk("rst_count0", 32'(count0), 32'd0);
    chk("rst_count1", 32'(count1), 32'd0);

    // Single beat to output 0
    ready0 = 1'b1;
    beat(1'b1, 1'b0, 1'b0, 32'hA5A5_A5A5);
    chk("t1_ready", 32'(ready_o), 32'd1);
    tick();
    beat(1'b0, 1'b0, 1'b0, '0);
    chk("t1_valid0", 32'(valid0), 32'd1);
    chk("t1_data0", data0, 32'hA5A5_A5A5);
    chk("t1_valid1", 32'(valid1), 32'd0);
    chk("t1_count0_pre", 32'(count0), 32'd0);
    tick();
    chk("t1_valid0_drained", 32'(valid0), 32'd0);
    chk("t1_count0", 32'(count0), 32'd1);

    // Alternating stream, data 1..8, both downstreams ready
    ready1 = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      beat(1'b1, 1'(i % 2 == 0), 1'b0, 32'(i));
      chk("t2_ready", 32'(ready_o), 32'd1);
      tick();
      if (i % 2 == 1) chk("t2_data0", data0, 32'(i));
      else            chk("t2_data1", data1, 32'(i));
    end
    beat(1'b0, 1'b0, 1'b0, '0);
    tick();
    chk("t2_count0", 32'(count0), 32'd5);
    chk("t2_count1", 32'(count1), 32'd4);
    chk("t2_valid0", 32'(valid0), 32'd0);
    chk("t2_valid1", 32'(valid1), 32'd0);

    // Backpressure on output 1 does not stall output 0
    ready1 = 1'b0;
    beat(1'b1, 1'b1, 1'b0, 32'h11);
    chk("t3_ready_a", 32'(ready_o), 32'd1);
    tick();
    chk("t3_data1_a", data1, 32'h11);
    beat(1'b1, 1'b1, 1'b0, 32'h22);
    chk("t3_ready_blocked", 32'(ready_o), 32'd0);
    beat(1'b1, 1'b0, 1'b0, 32'h33);
    chk("t3_ready_other", 32'(ready_o), 32'd1);
    tick();
    chk("t3_data0", data0, 32'h33);
    chk("t3_data1_hold", data1, 32'h11);
    chk("t3_valid1_hold", 32'(valid1), 32'd1);
    ready1 = 1'b1;
    beat(1'b1, 1'b1, 1'b0, 32'h22);
    chk("t3_ready_reload", 32'(ready_o), 32'd1);
    tick();
    beat(1'b0, 1'b0, 1'b0, '0);
    chk("t3_data1_b", data1, 32'h22);
    chk("t3_valid1_b", 32'(valid1), 32'd1);
    chk("t3_count1_a", 32'(count1), 32'd5);
    chk("t3_count0", 32'(count0), 32'd6);
    chk("t3_valid0", 32'(valid0), 32'd0);
    tick();
    chk("t3_count1_b", 32'(count1), 32'd6);
    chk("t3_valid1_c", 32'(valid1), 32'd0);

    // Broadcast: blocked while output 0 is stalled, then delivered to both
    ready0 = 1'b0;
    beat(1'b1, 1'b0, 1'b0, 32'hBEEF);
    tick();
    chk("t4_data0_fill", data0, 32'hBEEF);
    beat(1'b1, 1'b0, 1'b1, 32'hDEAD);
    chk("t4_ready_blocked", 32'(ready_o), 32'd0);
    tick();
    chk("t4_data0_hold", data0, 32'hBEEF);
    chk("t4_valid1_none", 32'(valid1), 32'd0);
    ready0 = 1'b1;
    #1;
    chk("t4_ready_ok", 32'(ready_o), 32'd1);
    tick();
    beat(1'b0, 1'b0, 1'b0, '0);
    chk("t4_data0", data0, 32'hDEAD);
    chk("t4_data1", data1, 32'hDEAD);
    chk("t4_valid0", 32'(valid0), 32'd1);
    chk("t4_valid1", 32'(valid1), 32'd1);
    chk("t4_count0_a", 32'(count0), 32'd7);
    tick();
    chk("t4_count0_b", 32'(count0), 32'd8);
    chk("t4_count1", 32'(count1), 32'd7);

    // Counter wrap: count0 runs 8..15 then 0 then 1
    for (int i = 0; i <= 8; i++) begin
      beat(1'b1, 1'b0, 1'b0, 32'(32'h100 + i));
      tick();
      chk("t5_data0", data0, 32'(32'h100 + i));
      chk("t5_count0", 32'(count0), 32'((8 + i) % 16));
    end
    beat(1'b0, 1'b0, 1'b0, '0);
    tick();
    chk("t5_count0_wrap1", 32'(count0), 32'd1);

    // Reset with both slots full and stalled; a beat offered during reset is dropped
    ready0 = 1'b0; ready1 = 1'b0;
    beat(1'b1, 1'b0, 1'b1, 32'h77);
    tick();
    chk("t6_valid0_full", 32'(valid0), 32'd1);
    chk("t6_valid1_full", 32'(valid1), 32'd1);
    rst = 1'b1;
    beat(1'b1, 1'b0, 1'b0, 32'h99);
    chk("t6_ready_in_rst", 32'(ready_o), 32'd1);
    tick();
    rst = 1'b0;
    beat(1'b0, 1'b0, 1'b0, '0);
    chk("t6_valid0", 32'(valid0), 32'd0);
    chk("t6_valid1", 32'(valid1), 32'd0);
    chk("t6_data0", data0, 32'd0);
    chk("t6_data1", data1, 32'd0);
    chk("t6_count0", 32'(count0), 32'd0);
    chk("t6_count1", 32'(count1), 32'd0);
    ready1 = 1'b1;
    beat(1'b1, 1'b1, 1'b0, 32'h5A);
    chk("t6_ready_after", 32'(ready_o), 32'd1);
    tick();
    beat(1'b0, 1'b0, 1'b0, '0);
    chk("t6_data1_after", data1, 32'h5A);
    chk("t6_valid1_after", 32'(valid1), 32'd1);
    chk("t6_valid0_after", 32'(valid0), 32'd0);
    tick();
    chk("t6_count1_after", 32'(count1), 32'd1);
    chk("t6_valid1_drained", 32'(valid1), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/demux1to2_stream.md
# demux1to2_stream

Registered 1-to-2 stream demultiplexer with valid/ready handshakes on every port. It steers each input beat to output 0 or output 1 by a per-beat select, or to both outputs in broadcast mode. It sits wherever one datapath result (for example an accumulator output or weight fetch) must be routed to one of two consumers, such as a next-layer buffer or a writeback path. Each output has its own one-entry holding register and its own delivered-beat counter.

## Interface
- DWidth, 32: data width of the input and both outputs
- CntWidth, 16: width of each per-output delivered-beat counter

Ports:
- clk_i  input  1  clock; all state updates on the rising edge
- rst_i  input  1  reset, synchronous and active-high
- valid_i  input  1  input beat valid
- ready_o  output  1  input beat accepted when valid_i && ready_o
- data_i  input  DWidth  input beat data
- select_i  input  1  destination: 0 = output 0, 1 = output 1; sampled with the beat
- broadcast_i  input  1  1 = send the beat to both outputs (overrides select_i); sampled with the beat
- valid0_o / valid1_o  output  1  output slot holds a beat
- ready0_i / ready1_i  input  1  downstream accepts; transfer when validN_o && readyN_i
- data0_o / data1_o  output  DWidth  output slot data, registered
- count0_o / count1_o  output  CntWidth  beats delivered on that output since reset, modulo 2^CntWidth

## Operation
- Each output N has slot state EMPTY (validN_o=0) or FULL (validN_o=1). Slot register drives dataN_o directly, so there is no combinational input-to-output data path.
- A slot can take a beat this cycle (canN) when it is EMPTY, or FULL and readyN_i=1.
- ready_o:
  - broadcast_i=1: can0 && can1
  - otherwise: can0 if select_i=0, can1 if select_i=1
  - ready_o is combinational from readyN_i, select_i, broadcast_i and slot state.
- On accept, each targeted slot loads data_i and becomes FULL. A non-targeted slot is unaffected.
- When validN_o && readyN_i and the slot is not reloaded in the same cycle, the slot becomes EMPTY.
- Simultaneous drain and reload of one slot: the slot stays FULL with the new data, so a full-rate stream sustains 1 beat/cycle.
- countN_o increments by 1 on every cycle with validN_o && readyN_i and wraps from all-ones to 0. A broadcast beat increments both counters when each copy drains.
- While validN_o=1 and readyN_i=0, dataN_o and validN_o hold stable, and the slot never drops or changes a pending beat.
- Ordering is preserved per output only. No ordering is defined between the two outputs.
- A beat with valid_i=0 has no effect; select_i, broadcast_i and data_i are don't-care.
- Reset (rst_i=1 at an edge), including mid-transfer:
  - validN_o=0, dataN_o=0, countN_o=0
  - all pending beats are discarded
  - while rst_i=1, ready_o evaluates against EMPTY slots, but nothing is accepted on that edge

## Timing
- Latency: a beat accepted at edge k appears on validN_o/dataN_o immediately after edge k and can be consumed at edge k+1. Minimum latency is 1 cycle.
- Throughput: 1 beat/cycle per output when the downstream is always ready. Alternating select values sustain 1 beat/cycle total.
- Broadcast is a single accept. If either slot cannot take the beat, ready_o=0 and neither slot loads. No partial broadcast is allowed.
- A blocked output never stalls beats to the other output unless they are broadcast.
- The counter update and the slot update occur on the same edge as the handshake.

## Test plan
- Reset, then drive select_i=0, data 0xA5A5A5A5, ready0_i=1 -> valid0_o=1 with data0_o=0xA5A5A5A5 one cycle after accept; count0_o=1 after the drain; valid1_o stays 0.
- Streaming, ready0_i=ready1_i=1, 8 beats alternating select, data 1..8 -> ready_o=1 every cycle; output 0 sees 1,3,5,7 and output 1 sees 2,4,6,8; count0_o=count1_o=4.
- Backpressure: ready1_i=0, send 0x11 to output 1, then 0x22 to output 1 -> ready_o=0 on the second beat; data1_o holds 0x11. A beat 0x33 to output 0 is accepted meanwhile. Raise ready1_i -> 0x11 drains, then 0x22 is accepted and delivered.
- Broadcast: broadcast_i=1, data 0xDEAD, with output 0 FULL and ready0_i=0 -> ready_o=0 and neither slot loads. With both ready -> both outputs show 0xDEAD one cycle later; both counters increment.
- Counter wrap with CntWidth=4: deliver 17 beats to output 0 -> count0_o goes 15 then 0 then 1.
- Reset mid-operation: both slots FULL and stalled, assert rst_i for 1 cycle -> valid0_o=valid1_o=0, data and counts 0 the next cycle; the next accepted beat is delivered normally.
